adder_21_core: RTL and testbench

- Registered ripple-carry adder slice: sums two WIDTH-bit unsigned operands plus a carry-in and produces a (WIDTH+1)-bit result.
- Default configuration: 7 input bits (3 + 3 + 1) and 4 output bits.
- Used as a leaf partition of a larger adder datapath; output is held in a register so the slice can be chained in a pipeline.

---
 rtl/adder_21_pkg.sv | 11 +
 rtl/adder_21_fa.sv | 16 +
 rtl/adder_21_core.sv | 73 +++++++
 tb/tb_adder_21_core.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/adder_21_pkg.sv
// Shared constants and types for the adder_21 slice.
package adder_21_pkg;

  // Default operand width; the result carries one extra bit for carry-out.
  localparam int DEFAULT_WIDTH = 3;
  localparam int RES_W         = DEFAULT_WIDTH + 1;

  typedef logic [DEFAULT_WIDTH-1:0] operand_t;
  typedef logic [RES_W-1:0]         result_t;

endpackage : adder_21_pkg

// File: rtl/adder_21_fa.sv
// Combinational 1-bit full adder: one cell of the ripple carry chain.
module adder_21_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry for one bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule : adder_21_fa

// File: rtl/adder_21_core.sv
// Registered ripple-carry adder slice: sum = a + b + cin at WIDTH+1 bits,
// one cycle of latency, throughput of one result per cycle.
// Optional macro ADDER_21_OVF_EN adds a registered signed-overflow output ovf.
//
// Valid semantics: in_valid qualifies a/b/cin in the cycle it is high; the
// slice has no ready (never stalls). out_valid is high in the cycle after an
// accepted input and marks sum as fresh; with in_valid low, sum keeps its
// previous value and out_valid is low. Reset clears both and wins over in_valid.
module adder_21_core
  import adder_21_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_21_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH:0]   sum,
  output logic             out_valid
);

  // Carry chain: c[0] is the carry-in, c[WIDTH] becomes the carry-out bit.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_bits;
  logic [WIDTH:0]   sum_next;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      adder_21_fa u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (c[gi]),
        .s  (s_bits[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  assign sum_next = {c[WIDTH], s_bits};

  // Output register and valid flop; sum only loads on accepted inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum <= sum_next;
      end
    end
  end

`ifdef ADDER_21_OVF_EN
  // Signed overflow of the WIDTH-bit sum: carries into and out of the MSB differ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule : adder_21_core

// File: tb/tb_adder_21_core.sv
// Directed bench for adder_21_core: reset, vector table, exhaustive sweep,
// hold and mid-stream reset sequences.
module tb_adder_21_core;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] a;
  logic [2:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       out_valid;
`ifdef ADDER_21_OVF_EN
  logic       ovf;
`endif

  int n_vec;
  int n_err;

  adder_21_core #(.WIDTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER_21_OVF_EN
    .ovf       (ovf),
`endif
    .sum       (sum),
    .out_valid (out_valid)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic [3:0] exp_sum;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs just after the edge, then sample just after the next edge.
  task automatic step(input logic r, input logic v, input logic [2:0] ai,
                      input logic [2:0] bi, input logic ci);
    rst_n    = r;
    in_valid = v;
    a        = ai;
    b        = bi;
    cin      = ci;
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed_ovf(input logic [2:0] x, input logic [2:0] y, input logic ci);
    int sx;
    int sy;
    int s;
    sx = x[2] ? int'(x) - 8 : int'(x);
    sy = y[2] ? int'(y) - 8 : int'(y);
    s  = sx + sy + int'(ci);
    return (s > 3) || (s < -4);
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;

    // a, b, cin, expected sum, expected signed overflow (hand computed)
    vecs[0] = '{3'd0, 3'd0, 1'b1, 4'b0001, 1'b0};
    vecs[1] = '{3'd1, 3'd1, 1'b0, 4'b0010, 1'b0};
    vecs[2] = '{3'd7, 3'd7, 1'b1, 4'b1111, 1'b0};
    vecs[3] = '{3'd3, 3'd5, 1'b0, 4'b1000, 1'b0};
    vecs[4] = '{3'd7, 3'd0, 1'b1, 4'b1000, 1'b0};
    vecs[5] = '{3'd3, 3'd1, 1'b0, 4'b0100, 1'b1};
    vecs[6] = '{3'd7, 3'd7, 1'b0, 4'b1110, 1'b0};
    vecs[7] = '{3'd4, 3'd4, 1'b0, 4'b1000, 1'b1};

    @(posedge clk); #1;

    // Reset held two cycles with valid max operands: outputs stay cleared.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 3'b111, 3'b111, 1'b1);
      check("reset_sum", 32'(sum), 32'd0);
      check("reset_valid", 32'(out_valid), 32'd0);
`ifdef ADDER_21_OVF_EN
      check("reset_ovf", 32'(ovf), 32'd0);
`endif
    end

    // Vector table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
`ifdef ADDER_21_OVF_EN
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
`endif
    end

    // Exhaustive sweep of the packed input {a,b,cin}.
    for (int i = 0; i < 128; i++) begin
      logic [6:0] pi;
      logic [3:0] exp_s;
      pi    = 7'(i);
      exp_s = 4'(pi[6:4]) + 4'(pi[3:1]) + 4'(pi[0]);
      step(1'b1, 1'b1, pi[6:4], pi[3:1], pi[0]);
      check($sformatf("sweep%0d_sum", i), 32'(sum), 32'(exp_s));
      check($sformatf("sweep%0d_valid", i), 32'(out_valid), 32'd1);
`ifdef ADDER_21_OVF_EN
      check($sformatf("sweep%0d_ovf", i), 32'(ovf), 32'(signed_ovf(pi[6:4], pi[3:1], pi[0])));
`endif
    end

    // Hold: result stays while in_valid is low, even with new operands.
    step(1'b1, 1'b1, 3'd2, 3'd3, 1'b0);
    check("hold_load_sum", 32'(sum), 32'b0101);
    check("hold_load_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 3'd7, 3'd7, 1'b1);
      check("hold_sum", 32'(sum), 32'b0101);
      check("hold_valid", 32'(out_valid), 32'd0);
    end

    // Reset mid-stream discards the result; reset wins over in_valid.
    step(1'b1, 1'b1, 3'd5, 3'd6, 1'b0);
    check("mid_sum", 32'(sum), 32'd11);
    check("mid_valid", 32'(out_valid), 32'd1);
    step(1'b0, 1'b1, 3'd5, 3'd6, 1'b0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);

    // Recovery after reset.
    step(1'b1, 1'b1, 3'd6, 3'd1, 1'b1);
    check("recover_sum", 32'(sum), 32'd8);
    check("recover_valid", 32'(out_valid), 32'd1);
    step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    check("drop_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_adder_21_core
